// File: rtl/operand_gather.sv
// Operand gather: aligns four independently arriving operands into one set.
// Optional partial-set timeout when OPERAND_GATHER_TIMEOUT_EN is defined.
module operand_gather #(
  parameter int DATA_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] c_i,
  input  logic signed [DATA_WIDTH-1:0] d_i,
  input  logic                         a_valid_i,
  input  logic                         b_valid_i,
  input  logic                         c_valid_i,
  input  logic                         d_valid_i,
  output logic                         a_ready_o,
  output logic                         b_ready_o,
  output logic                         c_ready_o,
  output logic                         d_ready_o,
  output logic signed [DATA_WIDTH-1:0] a_o,
  output logic signed [DATA_WIDTH-1:0] b_o,
  output logic signed [DATA_WIDTH-1:0] c_o,
  output logic signed [DATA_WIDTH-1:0] d_o,
  output logic                         valid_o,
  output logic                         drop_o
);

  typedef enum logic [1:0] {
    IDLE,
    PARTIAL,
    FIRE
  } state_e;

  state_e state_q;

  logic [3:0] full_q;
  logic [3:0] full_d;
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] acc;
  logic       valid_q;

  logic signed [DATA_WIDTH-1:0] a_q;
  logic signed [DATA_WIDTH-1:0] b_q;
  logic signed [DATA_WIDTH-1:0] c_q;
  logic signed [DATA_WIDTH-1:0] d_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  assign vld = {d_valid_i, c_valid_i,
                b_valid_i, a_valid_i};

  assign rdy    = ~full_q & {4{state_q != FIRE}};
  assign acc    = vld & rdy;
  assign full_d = full_q | acc;

  assign a_ready_o = rdy[0];
  assign b_ready_o = rdy[1];
  assign c_ready_o = rdy[2];
  assign d_ready_o = rdy[3];

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign c_o     = c_q;
  assign d_o     = d_q;
  assign valid_o = valid_q;

`ifdef OPERAND_GATHER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST =
    8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       drop_q;

  assign drop_o = drop_q;
`else
  assign drop_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      if (acc[0]) a_q <= a_i;
      if (acc[1]) b_q <= b_i;
      if (acc[2]) c_q <= c_i;
      if (acc[3]) d_q <= d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      full_q  <= '0;
      valid_q <= 1'b0;
`ifdef OPERAND_GATHER_TIMEOUT_EN
      drop_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef OPERAND_GATHER_TIMEOUT_EN
      drop_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE, PARTIAL: begin
          full_q <= full_d;
          if (&full_d) begin
            state_q <= FIRE;
            valid_q <= 1'b1;
          end else if (|acc) begin
            state_q <= PARTIAL;
`ifdef OPERAND_GATHER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
`ifdef OPERAND_GATHER_TIMEOUT_EN
          // Idle edge while partially filled
          else if (state_q == PARTIAL) begin
            if (cnt_q == CNT_LAST) begin
              full_q  <= '0;
              state_q <= IDLE;
              drop_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
`endif
        end
        FIRE: begin
          full_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          full_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_gather.sv
// Randomized scoreboard bench for operand_gather.
// Define OPERAND_GATHER_TIMEOUT_EN to also exercise the timeout path.
module tb_operand_gather;

  localparam int W = 5;
`ifdef OPERAND_GATHER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] a_i = '0;
  logic signed [W-1:0] b_i = '0;
  logic signed [W-1:0] c_i = '0;
  logic signed [W-1:0] d_i = '0;
  logic a_valid_i = 1'b0;
  logic b_valid_i = 1'b0;
  logic c_valid_i = 1'b0;
  logic d_valid_i = 1'b0;
  logic a_ready_o, b_ready_o;
  logic c_ready_o, d_ready_o;
  logic signed [W-1:0] a_o, b_o, c_o, d_o;
  logic valid_o, drop_o;

  always #5 clk = ~clk;

  operand_gather #(
    .DATA_WIDTH    (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .a_i      (a_i),
    .b_i      (b_i),
    .c_i      (c_i),
    .d_i      (d_i),
    .a_valid_i(a_valid_i),
    .b_valid_i(b_valid_i),
    .c_valid_i(c_valid_i),
    .d_valid_i(d_valid_i),
    .a_ready_o(a_ready_o),
    .b_ready_o(b_ready_o),
    .c_ready_o(c_ready_o),
    .d_ready_o(d_ready_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .c_o      (c_o),
    .d_o      (d_o),
    .valid_o  (valid_o),
    .drop_o   (drop_o)
  );

  int errors = 0;
  int checks = 0;

  logic [4*W-1:0] exp_q[$];

  // Reference: which operands are held, their values,
  // whether a set is on the output, idle edge count.
  logic [3:0]          m_have = '0;
  logic signed [W-1:0] m_val[4];
  bit                  m_fire = 0;
  bit                  m_drop = 0;
  int                  m_idle = 0;
  bit                  m_started = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] pk(
    input int a, input int b,
    input int c, input int d);
    logic [4*W-1:0] r;
    r[W-1:0]     = a[W-1:0];
    r[2*W-1:W]   = b[W-1:0];
    r[3*W-1:2*W] = c[W-1:0];
    r[4*W-1:3*W] = d[W-1:0];
    return r;
  endfunction

  task automatic model_step(input logic [3:0] v,
                            input logic [4*W-1:0] xs,
                            input bit r);
    logic [3:0] got;
    if (r) begin
      m_have = '0;
      for (int i = 0; i < 4; i++) m_val[i] = '0;
      m_fire = 0;
      m_drop = 0;
      m_idle = 0;
      m_started = 1;
    end else if (m_fire) begin
      m_fire = 0;
      m_drop = 0;
      m_have = '0;
    end else begin
      m_drop = 0;
      got = v & ~m_have;
      for (int i = 0; i < 4; i++)
        if (got[i]) m_val[i] = xs[i*W +: W];
      m_have = m_have | got;
      if (m_have == 4'hF) begin
        m_fire = 1;
        m_idle = 0;
        exp_q.push_back({m_val[3], m_val[2],
                         m_val[1], m_val[0]});
      end else if (got != 0) begin
        m_idle = 0;
      end else if (m_have != 0) begin
        m_idle++;
`ifdef OPERAND_GATHER_TIMEOUT_EN
        if (m_idle == TO) begin
          m_have = '0;
          m_idle = 0;
          m_drop = 1;
        end
`endif
      end
    end
  endtask

  function automatic logic [3:0] m_rdy();
    return ~m_have & {4{~m_fire}};
  endfunction

  task automatic cycle(input logic [3:0] v,
                       input logic [4*W-1:0] xs,
                       input bit r);
    if (m_started) begin
      chk("ready", 32'({d_ready_o, c_ready_o,
                        b_ready_o, a_ready_o}),
          32'(m_rdy()));
      chk("valid", 32'(valid_o), 32'(m_fire));
      chk("drop", 32'(drop_o), 32'(m_drop));
      chk("a_o", 32'(a_o), 32'(m_val[0]));
      chk("b_o", 32'(b_o), 32'(m_val[1]));
      chk("c_o", 32'(c_o), 32'(m_val[2]));
      chk("d_o", 32'(d_o), 32'(m_val[3]));
    end
    {d_valid_i, c_valid_i,
     b_valid_i, a_valid_i} = v;
    a_i = xs[W-1:0];
    b_i = xs[2*W-1:W];
    c_i = xs[3*W-1:2*W];
    d_i = xs[4*W-1:3*W];
    rst = r;
    @(posedge clk);
    model_step(v, xs, r);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(4'h0, '0, 1'b0);
  endtask

  initial begin : monitor
    logic [4*W-1:0] e;
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_set", 32'(valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("set_data",
              32'({d_o, c_o, b_o, a_o}), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    logic [3:0]     pend;
    logic [4*W-1:0] pdat;
    logic [3:0]     rdy;
    bit             r;
    int             rate;
    for (int i = 0; i < 4; i++) m_val[i] = '0;
    @(negedge clk);
    cycle(4'h0, '0, 1'b1);
    cycle(4'hF, pk(9, 9, 9, 9), 1'b1);
    idle(1);

    cycle(4'hF, pk(3, 1, 2, -1), 1'b0);
    idle(2);

    cycle(4'h1, pk(5, 0, 0, 0), 1'b0);
    idle(1);
    cycle(4'h4, pk(0, 0, -6, 0), 1'b0);
    cycle(4'h2, pk(0, 11, 0, 0), 1'b0);
    idle(1);
    cycle(4'h8, pk(0, 0, 0, -16), 1'b0);
    idle(2);

    cycle(4'h1, pk(4, 0, 0, 0), 1'b0);
    cycle(4'hF, pk(7, -2, 6, -7), 1'b0);
    cycle(4'h1, pk(7, 0, 0, 0), 1'b0);
    cycle(4'h1, pk(7, 0, 0, 0), 1'b0);
    cycle(4'hE, pk(0, 1, 15, -1), 1'b0);
    idle(2);

    cycle(4'h1, pk(1, 0, 0, 0), 1'b0);
    idle(6);
    cycle(4'hF, pk(2, 3, 4, 5), 1'b0);
    idle(2);

    cycle(4'h1, pk(-3, 0, 0, 0), 1'b0);
    idle(3);
    cycle(4'h2, pk(0, 8, 0, 0), 1'b0);
    cycle(4'h4, pk(0, 0, 12, 0), 1'b0);
    cycle(4'h8, pk(0, 0, 0, 13), 1'b0);
    idle(2);

    cycle(4'h1, pk(6, 0, 0, 0), 1'b0);
    cycle(4'h2, pk(0, -9, 0, 0), 1'b0);
    idle(1);
    cycle(4'h0, '0, 1'b1);
    idle(1);
    cycle(4'hF, pk(-1, -2, -3, -4), 1'b0);
    idle(2);

    pend = '0;
    pdat = '0;
    for (int n = 0; n < 4000; n++) begin
      rate = (n % 1000 < 500) ? 1 : 7;
      r = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++)
        if (!pend[i] &&
            $urandom_range(0, rate) == 0) begin
          pend[i] = 1'b1;
          pdat[i*W +: W] = W'($urandom);
        end
      rdy = m_rdy();
      cycle(pend, pdat, r);
      if (r) pend = '0;
      else pend = pend & ~rdy;
    end
    idle(TO + 3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_gather.md
OPERAND_GATHER -- requirements
Module: operand_gather

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, giving the operand width in bits (signed).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the idle-cycle limit for a partial set (range 2..255).
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports a_i/b_i/c_i/d_i  input  DATA_WIDTH  signed operand data.
REQ-006 SHALL have ports a_valid_i/b_valid_i/c_valid_i/d_valid_i  input  1  per-operand valid.
REQ-007 SHALL have ports a_ready_o/b_ready_o/c_ready_o/d_ready_o  output  1  per-operand ready.
REQ-008 SHALL have ports a_o/b_o/c_o/d_o  output  DATA_WIDTH  aligned operand set to the downstream arithmetic pipeline.
REQ-009 SHALL have port valid_o  output  1  aligned set valid; drives all four downstream valid inputs together.
REQ-010 SHALL have port drop_o  output  1  one-cycle pulse when a partial set is discarded.

Function
REQ-011 SHALL hold, per operand x, a data register x_q and a flag full_x.
REQ-012 SHALL capture x_i into x_q and set full_x on a rising edge where x_valid_i & x_ready_o.
REQ-013 SHALL drive x_ready_o = ~full_x & (state != FIRE), combinationally from registers only.
REQ-014 SHALL implement states IDLE (no flags set), PARTIAL (1..3 flags set) and FIRE (all four set).
REQ-015 SHALL transition IDLE->PARTIAL on any accept, IDLE->FIRE when all four are accepted on one edge, and PARTIAL->FIRE when the last missing operand is accepted.
REQ-016 SHALL hold valid_o = 1 for exactly one cycle while in FIRE, with x_o = x_q; then clear all flags and go to IDLE on the next edge.
REQ-017 SHALL drive x_o = x_q at all times; x_q is unchanged except by capture or reset.
REQ-018 SHALL give a latency of one cycle from the edge that completes a set to valid_o high, and a maximum throughput of one set per two cycles.
REQ-019 SHALL ignore x_valid_i while full_x is set; the held value is not overwritten and the source must hold its data until ready.
REQ-020 SHALL capture simultaneous arrivals of any subset of operands on the same edge.
REQ-021 SHALL pass data through unmodified; no arithmetic, sign extension or saturation.

Reset
REQ-022 SHALL, on an edge with rst_i = 1, clear all x_q to 0, clear all flags, clear the timeout counter, enter IDLE and drive valid_o = 0 and drop_o = 0; this includes reset in PARTIAL or FIRE.
REQ-023 SHALL give reset priority over capture, fire and timeout on the same edge.
REQ-024 SHALL drive all ready_o = 1 in the first cycle after reset release.

Configuration
REQ-025 SHALL compile the timeout feature only when the macro OPERAND_GATHER_TIMEOUT_EN is defined.
REQ-026 SHALL, with the macro defined:
  - count edges in PARTIAL with no accept, and restart the count on each accept;
  - on the edge where the count reaches TIMEOUT_CYCLES, clear all flags and go to IDLE;
  - raise drop_o for the following cycle;
  - if an accept coincides with expiry, perform the accept and restart the count; no drop occurs.
REQ-027 SHALL, without the macro, wait in PARTIAL indefinitely, contain no counter, and tie drop_o = 0.

Verification
REQ-028 SHALL cover: all four valid at edge 0 with a=3, b=1, c=2, d=-1 -> valid_o = 1 only in cycle 0..1 with those values; all readys 0 in that cycle and 1 from edge 1.
REQ-029 SHALL cover: staggered arrival a@edge0, c@edge2, b@edge3, d@edge5 -> valid_o high in cycle 5..6 only; a_ready_o low from edge 0 to edge 6.
REQ-030 SHALL cover: a=4 accepted, then a_valid_i held with a=7 -> a_o stays 4 through FIRE; a=7 accepted on the first edge after FIRE.
REQ-031 SHALL cover, with the macro defined and TIMEOUT_CYCLES=4: only a=1 accepted @edge0 -> flags clear @edge4; drop_o = 1 in cycle 4..5; valid_o never set; a_ready_o = 1 from edge 4.
REQ-032 SHALL cover, with the macro defined and TIMEOUT_CYCLES=4: a@edge0, b@edge4 -> no drop_o, count restarts; c@edge5 and d@edge6 -> valid_o in cycle 6..7.
REQ-033 SHALL cover: a and b accepted, then rst_i = 1 @edge3 -> all outputs 0 and readys 1 after edge 3; a later complete set fires normally.
